// File: rtl/axi_dma_cmd_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_dma_cmd_arbiter: round-robin arbiter sharing the DMA command port,   |
// | absorbs zero-length commands. Option macro: AXI_DMA_CMD_ARB_PRIO_EN      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module axi_dma_cmd_arbiter #(
  parameter  int REQ_COUNT = 4,
  parameter  int ADDR_WD   = 32,
  parameter  int LEN_WD    = 32,
  localparam int ID_WD     = $clog2(REQ_COUNT)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [REQ_COUNT-1:0]           req_valid,
`ifdef AXI_DMA_CMD_ARB_PRIO_EN
  input  logic [REQ_COUNT-1:0]           req_prio,
`endif
  input  logic [REQ_COUNT*ADDR_WD-1:0]   req_src_addr,
  input  logic [REQ_COUNT*ADDR_WD-1:0]   req_dst_addr,
  input  logic [REQ_COUNT*2-1:0]         req_burst,
  input  logic [REQ_COUNT*LEN_WD-1:0]    req_len,
  input  logic [REQ_COUNT*3-1:0]         req_size,
  output logic [REQ_COUNT-1:0]           req_ready,
  output logic                           cmd_valid,
  output logic [ADDR_WD-1:0]             cmd_src_addr,
  output logic [ADDR_WD-1:0]             cmd_dst_addr,
  output logic [1:0]                     cmd_burst,
  output logic [LEN_WD-1:0]              cmd_len,
  output logic [2:0]                     cmd_size,
  output logic [ID_WD-1:0]               cmd_id,
  input  logic                           cmd_ready,
  output logic                           drop_pulse,
  output logic [ID_WD-1:0]               drop_id,
  output logic                           busy
);

  localparam logic [ID_WD-1:0] C_LAST = ID_WD'(REQ_COUNT - 1);
  localparam logic [ID_WD:0]   C_NREQ = (ID_WD + 1)'(REQ_COUNT);

  logic [ADDR_WD-1:0] w_src   [REQ_COUNT];
  logic [ADDR_WD-1:0] w_dst   [REQ_COUNT];
  logic [1:0]         w_burst [REQ_COUNT];
  logic [LEN_WD-1:0]  w_len   [REQ_COUNT];
  logic [2:0]         w_size  [REQ_COUNT];

  logic                   r_cmd_valid;
  logic [ADDR_WD-1:0]     r_cmd_src;
  logic [ADDR_WD-1:0]     r_cmd_dst;
  logic [1:0]             r_cmd_burst;
  logic [LEN_WD-1:0]      r_cmd_len;
  logic [2:0]             r_cmd_size;
  logic [ID_WD-1:0]       r_cmd_id;
  logic                   r_drop_pulse;
  logic [ID_WD-1:0]       r_drop_id;
  logic [ID_WD-1:0]       r_last_grant;

  logic [REQ_COUNT-1:0]   w_cand;
  logic [2*REQ_COUNT-2:0] w_dbl;
  logic [REQ_COUNT-1:0]   w_rot;
  logic [ID_WD-1:0]       w_start;
  logic [ID_WD-1:0]       w_off;
  logic [ID_WD:0]         w_sum;
  logic [ID_WD-1:0]       w_winner;
  logic                   w_found;
  logic                   w_free;
  logic                   w_grant;
  logic [LEN_WD-1:0]      w_len_sel;

  for (genvar i = 0; i < REQ_COUNT; i++) begin : g_unpack
    assign w_src[i]   = req_src_addr[i*ADDR_WD +: ADDR_WD];
    assign w_dst[i]   = req_dst_addr[i*ADDR_WD +: ADDR_WD];
    assign w_burst[i] = req_burst[i*2 +: 2];
    assign w_len[i]   = req_len[i*LEN_WD +: LEN_WD];
    assign w_size[i]  = req_size[i*3 +: 3];
  end

`ifdef AXI_DMA_CMD_ARB_PRIO_EN
  logic [REQ_COUNT-1:0] w_hi;
  assign w_hi   = req_valid & req_prio;
  assign w_cand = (|w_hi) ? w_hi : req_valid;
`else
  assign w_cand = req_valid;
`endif

  // Rotate candidates so the search always starts at bit 0, then un-rotate the hit.
  always_comb begin
    w_start  = (r_last_grant == C_LAST) ? '0 : r_last_grant + 1'b1;
    w_dbl    = {w_cand[REQ_COUNT-2:0], w_cand};
    w_rot    = w_cand;
    w_found  = 1'b0;
    w_off    = '0;
    w_sum    = '0;
    w_winner = '0;
    for (int s = 0; s < REQ_COUNT; s++) begin
      if (w_start == ID_WD'(s)) begin
        w_rot = w_dbl[s +: REQ_COUNT];
      end
    end
    for (int i = REQ_COUNT - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_found = 1'b1;
        w_off   = ID_WD'(i);
      end
    end
    w_sum = {1'b0, w_start} + {1'b0, w_off};
    if (w_sum >= C_NREQ) begin
      w_sum = w_sum - C_NREQ;
    end
    w_winner = w_sum[ID_WD-1:0];
  end

  assign w_free    = !r_cmd_valid || cmd_ready;
  assign w_grant   = w_found && w_free;
  assign w_len_sel = w_len[w_winner];

  for (genvar i = 0; i < REQ_COUNT; i++) begin : g_ready
    assign req_ready[i] = w_grant && (w_winner == ID_WD'(i));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd_valid  <= 1'b0;
      r_cmd_src    <= '0;
      r_cmd_dst    <= '0;
      r_cmd_burst  <= '0;
      r_cmd_len    <= '0;
      r_cmd_size   <= '0;
      r_cmd_id     <= '0;
      r_drop_pulse <= 1'b0;
      r_drop_id    <= '0;
      r_last_grant <= C_LAST;
    end else begin
      r_drop_pulse <= 1'b0;
      if (w_free) begin
        r_cmd_valid <= 1'b0;
      end
      if (w_grant) begin
        r_last_grant <= w_winner;
        if (w_len_sel != '0) begin
          r_cmd_valid <= 1'b1;
          r_cmd_src   <= w_src[w_winner];
          r_cmd_dst   <= w_dst[w_winner];
          r_cmd_burst <= w_burst[w_winner];
          r_cmd_len   <= w_len_sel;
          r_cmd_size  <= w_size[w_winner];
          r_cmd_id    <= w_winner;
        end else begin
          // Zero-length command: consumed and reported, never forwarded.
          r_drop_pulse <= 1'b1;
          r_drop_id    <= w_winner;
        end
      end
    end
  end

  assign cmd_valid    = r_cmd_valid;
  assign cmd_src_addr = r_cmd_src;
  assign cmd_dst_addr = r_cmd_dst;
  assign cmd_burst    = r_cmd_burst;
  assign cmd_len      = r_cmd_len;
  assign cmd_size     = r_cmd_size;
  assign cmd_id       = r_cmd_id;
  assign drop_pulse   = r_drop_pulse;
  assign drop_id      = r_drop_id;
  assign busy         = r_cmd_valid | (|req_valid);

endmodule
`default_nettype wire

// File: tb/tb_axi_dma_cmd_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axi_dma_cmd_arbiter: directed bench with round-robin reference model  |
// | and expected-command queue. Revision: 1.0                                |
// +--------------------------------------------------------------------------+
module tb_axi_dma_cmd_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LW = 32;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_prio = '0;
  logic [N*AW-1:0] src_bus, dst_bus;
  logic [N*2-1:0] burst_bus;
  logic [N*LW-1:0] len_bus;
  logic [N*3-1:0] size_bus;
  logic [N-1:0] req_ready;
  logic cmd_valid, cmd_ready = 1'b0, drop_pulse, busy;
  logic [AW-1:0] cmd_src_addr, cmd_dst_addr;
  logic [1:0] cmd_burst;
  logic [LW-1:0] cmd_len;
  logic [2:0] cmd_size;
  logic [IW-1:0] cmd_id, drop_id;

  logic [AW-1:0] src [N];
  logic [AW-1:0] dst [N];
  logic [LW-1:0] len [N];
  logic [1:0] burst [N];
  logic [2:0] size [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      src_bus[i*AW +: AW] = src[i];
      dst_bus[i*AW +: AW] = dst[i];
      len_bus[i*LW +: LW] = len[i];
      burst_bus[i*2 +: 2] = burst[i];
      size_bus[i*3 +: 3]  = size[i];
    end
  end

  always #5 clk = ~clk;

  axi_dma_cmd_arbiter #(.REQ_COUNT(N), .ADDR_WD(AW), .LEN_WD(LW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid),
`ifdef AXI_DMA_CMD_ARB_PRIO_EN
    .req_prio(req_prio),
`endif
    .req_src_addr(src_bus), .req_dst_addr(dst_bus), .req_burst(burst_bus),
    .req_len(len_bus), .req_size(size_bus), .req_ready(req_ready),
    .cmd_valid(cmd_valid), .cmd_src_addr(cmd_src_addr), .cmd_dst_addr(cmd_dst_addr),
    .cmd_burst(cmd_burst), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_id(cmd_id),
    .cmd_ready(cmd_ready), .drop_pulse(drop_pulse), .drop_id(drop_id), .busy(busy)
  );

  typedef struct {
    int id;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] len;
    logic [1:0] burst;
    logic [2:0] size;
  } exp_t;
  exp_t sbq[$];

  int n_cmp = 0;
  int n_fail = 0;
  int m_last = N - 1;
  bit m_cv = 0;
  bit m_drop = 0;
  int m_drop_id = 0;
  bit fair_active = 0;
  int fair_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int pick(input logic [N-1:0] cand, input int last);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (last + k) % N;
      if (cand[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock: check outputs at negedge against the model, advance the model,
  // then return just after the next rising edge so the caller can drive inputs.
  task automatic step();
    logic [N-1:0] cand, exp_rdy;
    int g;
    bit free;
    exp_t e;
    @(negedge clk);
    chk("cmd_valid", 64'(cmd_valid), 64'(m_cv));
    chk("drop_pulse", 64'(drop_pulse), 64'(m_drop));
    if (m_drop) chk("drop_id", 64'(drop_id), 64'(m_drop_id));
    chk("busy", 64'(busy), 64'(m_cv | (|req_valid)));
    free = !m_cv || cmd_ready;
    cand = req_valid;
`ifdef AXI_DMA_CMD_ARB_PRIO_EN
    if (|(req_valid & req_prio)) cand = req_valid & req_prio;
`endif
    g = pick(cand, m_last);
    exp_rdy = '0;
    if (free && g >= 0) exp_rdy = N'(1) << g;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (fair_active) begin
      if (req_ready[3]) begin
        chk("fairness", 64'(fair_cnt <= N - 1), 64'd1);
        fair_active = 0;
      end else if (|req_ready) begin
        fair_cnt++;
      end
    end
    if (m_cv) begin
      chk("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
      if (sbq.size() != 0) begin
        e = sbq[0];
        chk("cmd_id", 64'(cmd_id), 64'(e.id));
        chk("cmd_src", 64'(cmd_src_addr), 64'(e.src));
        chk("cmd_dst", 64'(cmd_dst_addr), 64'(e.dst));
        chk("cmd_len", 64'(cmd_len), 64'(e.len));
        chk("cmd_burst", 64'(cmd_burst), 64'(e.burst));
        chk("cmd_size", 64'(cmd_size), 64'(e.size));
        if (cmd_ready) void'(sbq.pop_front());
      end
    end
    if (free) m_cv = 0;
    m_drop = 0;
    if (free && g >= 0) begin
      m_last = g;
      if (len[g] != 0) begin
        e.id = g; e.src = src[g]; e.dst = dst[g]; e.len = len[g];
        e.burst = burst[g]; e.size = size[g];
        sbq.push_back(e);
        m_cv = 1;
      end else begin
        m_drop = 1;
        m_drop_id = g;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      src[i]   = AW'(32'h1000 * i);
      dst[i]   = AW'(32'h8000 + 32'h100 * i);
      len[i]   = LW'(32'h40);
      burst[i] = 2'b01;
      size[i]  = 3'(i + 1);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("rst_drop_pulse", 64'(drop_pulse), 64'd0);
    chk("rst_cmd_id", 64'(cmd_id), 64'd0);
    chk("rst_cmd_src", 64'(cmd_src_addr), 64'd0);
    chk("rst_drop_id", 64'(drop_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // All four requesters valid, controller always ready: 0,1,2,3,0,...
    req_valid = 4'b1111;
    cmd_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_seq", 64'(cmd_id), 64'(k % N));
    end
    req_valid = '0;
    step();
    step();

    // Stall with requester 2 loaded; others valid must not be accepted.
    req_valid = 4'b0100;
    cmd_ready = 1'b0;
    step();
    req_valid = 4'b1011;
    for (int k = 0; k < 10; k++) step();
    req_valid = '0;
    cmd_ready = 1'b1;
    step();
    step();

    // Zero-length command from requester 1 after a grant to requester 0.
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    step();
    len[1] = '0;
    req_valid = 4'b0110;
    step();
    chk("drop_now", 64'(drop_pulse), 64'd1);
    chk("drop_now_id", 64'(drop_id), 64'd1);
    chk("drop_no_cmd", 64'(cmd_valid), 64'd0);
    req_valid = 4'b0100;
    step();
    chk("drop_one_cycle", 64'(drop_pulse), 64'd0);
    chk("after_drop_id", 64'(cmd_id), 64'd2);
    req_valid = '0;
    step();
    step();
    len[1] = LW'(32'h40);

    // Requester 3 held valid against back-to-back requesters 0 and 1.
    fair_active = 1;
    fair_cnt = 0;
    req_valid = 4'b1011;
    for (int k = 0; k < 8; k++) step();
    chk("fair_granted", 64'(fair_active), 64'd0);
    req_valid = '0;
    step();
    step();

    // Asynchronous reset while a command is stalled.
    req_valid = 4'b0001;
    cmd_ready = 1'b0;
    step();
    req_valid = '0;
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 64'(cmd_valid), 64'd0);
    chk("async_rst_id", 64'(cmd_id), 64'd0);
    m_cv = 0; m_drop = 0; m_last = N - 1;
    sbq.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = 4'b1001;
    cmd_ready = 1'b1;
    step();
    chk("post_rst_valid", 64'(cmd_valid), 64'd1);
    chk("post_rst_id", 64'(cmd_id), 64'd0);
    req_valid = '0;
    step();
    step();

`ifdef AXI_DMA_CMD_ARB_PRIO_EN
    req_valid = 4'b1001;
    req_prio  = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("prio_id", 64'(cmd_id), 64'd3);
    end
    req_prio = '0;
    step();
    chk("prio_clear_id", 64'(cmd_id), 64'd0);
    req_valid = '0;
    step();
    step();
`endif

    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
